// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, functs, ALU controls, memory sizing.
package mips_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MEM_DEPTH = 64;
    localparam int unsigned MEM_AW    = 6;
    localparam int unsigned REG_AW    = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Main-decoder class of ALU work; the ALU decoder refines FUNCT into a control code.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{default: '0};

    function automatic logic [XLEN-1:0] sign_extend16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_imem.sv
// Word-addressed instruction ROM with combinational read; contents are loaded from outside.
module mips_imem
    import mips_pkg::*;
(
    input  logic [MEM_AW-1:0] addr,
    output logic [XLEN-1:0]   instr
);

    logic [XLEN-1:0] Memory [0:MEM_DEPTH-1];

    assign instr = Memory[addr];

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32 register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    logic [XLEN-1:0] RegFile [0:31];

    always_ff @(posedge clk) begin
        if (we && (wa != REG_AW'(0))) begin
            RegFile[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == REG_AW'(0)) ? XLEN'(0) : RegFile[ra1];
    assign rd2 = (ra2 == REG_AW'(0)) ? XLEN'(0) : RegFile[ra2];

endmodule

// File: rtl/mips_complete.sv
// Single-cycle MIPS subset (add/sub/and/or/slt, lw, sw, beq, j) with every datapath/control net exported.
// Defining MIPS_COMPLETE_ADDI_EN adds addi; otherwise opcode 001000 executes as a nop.
module mips_complete
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   PCNext,
    output logic [XLEN-1:0]   PCplus4,
    output logic [XLEN-1:0]   Instr,
    output logic [XLEN-1:0]   Signlmm,
    output logic [XLEN-1:0]   shifted,
    output logic [XLEN-1:0]   PCBranch,
    output logic [XLEN-1:0]   ReadData1,
    output logic [XLEN-1:0]   ReadData2,
    output logic [XLEN-1:0]   SrcB,
    output logic [XLEN-1:0]   ALUResult,
    output logic              Zero,
    output logic [XLEN-1:0]   ReadData,
    output logic [XLEN-1:0]   Result,
    output logic [REG_AW-1:0] WriteReg,
    output logic              RegWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              MemWrite,
    output logic              Branch,
    output logic              ALUSrc,
    output logic              Jump,
    output logic [2:0]        ALUControl,
    output logic              PCSrc
);

`ifdef MIPS_COMPLETE_ADDI_EN
    localparam logic ADDI_EN = 1'b1;
`else
    localparam logic ADDI_EN = 1'b0;
`endif

    logic [5:0]      opcode;
    logic [5:0]      funct;
    ctrl_t           main_ctrl;
    ctrl_t           ctrl;
    logic [2:0]      alu_dec;
    logic            funct_ok;
    logic            rf_we;
    logic [XLEN-1:0] data_mem [0:MEM_DEPTH-1];

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= XLEN'(0);
        end else begin
            PC <= PCNext;
        end
    end

    mips_imem im (
        .addr  (PC[7:2]),
        .instr (Instr)
    );

    // Main decoder: opcode -> control class.
    always_comb begin
        main_ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                main_ctrl.reg_write = 1'b1;
                main_ctrl.reg_dst   = 1'b1;
                main_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.alu_src    = 1'b1;
                main_ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                main_ctrl.mem_write = 1'b1;
                main_ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                main_ctrl.branch = 1'b1;
                main_ctrl.alu_op = ALUOP_SUB;
            end
            OP_J: begin
                main_ctrl.jump = 1'b1;
            end
            OP_ADDI: begin
                if (ADDI_EN) begin
                    main_ctrl.reg_write = 1'b1;
                    main_ctrl.alu_src   = 1'b1;
                end
            end
            default: main_ctrl = CTRL_NOP;
        endcase
    end

    // ALU decoder; an unknown funct turns the whole R-type instruction into a nop.
    always_comb begin
        alu_dec  = ALU_ADD;
        funct_ok = 1'b1;
        case (main_ctrl.alu_op)
            ALUOP_SUB: alu_dec = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_dec = ALU_ADD;
                    FUNCT_SUB: alu_dec = ALU_SUB;
                    FUNCT_AND: alu_dec = ALU_AND;
                    FUNCT_OR:  alu_dec = ALU_OR;
                    FUNCT_SLT: alu_dec = ALU_SLT;
                    default: begin
                        alu_dec  = ALU_ADD;
                        funct_ok = 1'b0;
                    end
                endcase
            end
            default: alu_dec = ALU_ADD;
        endcase
    end

    assign ctrl       = funct_ok ? main_ctrl : CTRL_NOP;
    assign ALUControl = funct_ok ? alu_dec : ALU_ADD;

    assign RegWrite = ctrl.reg_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign MemWrite = ctrl.mem_write;
    assign Branch   = ctrl.branch;
    assign ALUSrc   = ctrl.alu_src;
    assign Jump     = ctrl.jump;

    assign WriteReg = RegDst ? Instr[15:11] : Instr[20:16];
    assign rf_we    = RegWrite & ~reset;

    mips_regfile rf (
        .clk (clk),
        .we  (rf_we),
        .ra1 (Instr[25:21]),
        .ra2 (Instr[20:16]),
        .wa  (WriteReg),
        .wd  (Result),
        .rd1 (ReadData1),
        .rd2 (ReadData2)
    );

    assign Signlmm = sign_extend16(Instr[15:0]);
    assign shifted = {Signlmm[XLEN-3:0], 2'b00};
    assign SrcB    = ALUSrc ? Signlmm : ReadData2;

    always_comb begin
        ALUResult = XLEN'(0);
        case (ALUControl)
            ALU_ADD: ALUResult = ReadData1 + SrcB;
            ALU_SUB: ALUResult = ReadData1 - SrcB;
            ALU_AND: ALUResult = ReadData1 & SrcB;
            ALU_OR:  ALUResult = ReadData1 | SrcB;
            ALU_SLT: ALUResult = XLEN'($signed(ReadData1) < $signed(SrcB));
            default: ALUResult = XLEN'(0);
        endcase
    end

    assign Zero = (ALUResult == XLEN'(0));

    // Data memory: cleared on reset, written with rt on sw.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                data_mem[i] <= XLEN'(0);
            end
        end else if (MemWrite) begin
            data_mem[ALUResult[7:2]] <= ReadData2;
        end
    end

    assign ReadData = data_mem[ALUResult[7:2]];
    assign Result   = MemtoReg ? ReadData : ALUResult;

    assign PCplus4  = PC + XLEN'(4);
    assign PCBranch = PCplus4 + shifted;
    assign PCSrc    = Branch & Zero;
    assign PCNext   = Jump  ? {PCplus4[31:28], Instr[25:0], 2'b00}
                    : PCSrc ? PCBranch : PCplus4;

endmodule

// File: tb/tb_mips_complete.sv
// Directed program bench for mips_complete; expectations are queued per cycle and checked by a monitor.
module tb_mips_complete;

`ifdef MIPS_COMPLETE_ADDI_EN
    localparam bit ADDI = 1'b1;
`else
    localparam bit ADDI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC, PCNext, PCplus4, Instr, Signlmm, shifted, PCBranch;
    logic [31:0] ReadData1, ReadData2, SrcB, ALUResult, ReadData, Result;
    logic [4:0]  WriteReg;
    logic [2:0]  ALUControl;
    logic        Zero, RegWrite, RegDst, MemtoReg, MemWrite, Branch, ALUSrc, Jump, PCSrc;

    mips_complete dut (
        .clk(clk), .reset(reset), .PC(PC), .PCNext(PCNext), .PCplus4(PCplus4),
        .Instr(Instr), .Signlmm(Signlmm), .shifted(shifted), .PCBranch(PCBranch),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SrcB(SrcB), .ALUResult(ALUResult),
        .Zero(Zero), .ReadData(ReadData), .Result(Result), .WriteReg(WriteReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .Branch(Branch), .ALUSrc(ALUSrc), .Jump(Jump), .ALUControl(ALUControl), .PCSrc(PCSrc)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_PC, S_PCNEXT, S_PCPLUS4, S_INSTR, S_SIGNIMM, S_SHIFTED, S_PCBRANCH, S_RD1, S_RD2,
        S_SRCB, S_ALU, S_ZERO, S_RDATA, S_RESULT, S_WREG, S_REGWRITE, S_REGDST, S_MEMTOREG,
        S_MEMWRITE, S_BRANCH, S_ALUSRC, S_JUMP, S_ALUCTL, S_PCSRC, S_REG2, S_DMEM0
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] probe(input sig_e s);
        case (s)
            S_PC:       return PC;
            S_PCNEXT:   return PCNext;
            S_PCPLUS4:  return PCplus4;
            S_INSTR:    return Instr;
            S_SIGNIMM:  return Signlmm;
            S_SHIFTED:  return shifted;
            S_PCBRANCH: return PCBranch;
            S_RD1:      return ReadData1;
            S_RD2:      return ReadData2;
            S_SRCB:     return SrcB;
            S_ALU:      return ALUResult;
            S_ZERO:     return 32'(Zero);
            S_RDATA:    return ReadData;
            S_RESULT:   return Result;
            S_WREG:     return 32'(WriteReg);
            S_REGWRITE: return 32'(RegWrite);
            S_REGDST:   return 32'(RegDst);
            S_MEMTOREG: return 32'(MemtoReg);
            S_MEMWRITE: return 32'(MemWrite);
            S_BRANCH:   return 32'(Branch);
            S_ALUSRC:   return 32'(ALUSrc);
            S_JUMP:     return 32'(Jump);
            S_ALUCTL:   return 32'(ALUControl);
            S_PCSRC:    return 32'(PCSrc);
            S_REG2:     return dut.rf.RegFile[2];
            S_DMEM0:    return dut.data_mem[0];
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void want(input sig_e s, input logic [31:0] v);
        sb.push_back('{sig: s, exp: v});
    endfunction

    // Monitor: drains every expectation queued for the current cycle, mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = probe(e.sig);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s @PC=%h: got %h expected %h", e.sig.name(), PC, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 64; i++) dut.im.Memory[i] = 32'h0000_003F;
        dut.im.Memory[0]  = 32'h0021_1020;  // add  $2,$1,$1
        dut.im.Memory[1]  = 32'h8C03_0000;  // lw   $3,0($0)
        dut.im.Memory[2]  = 32'hAC02_0000;  // sw   $2,0($0)
        dut.im.Memory[3]  = 32'h1043_0002;  // beq  $2,$3,2
        dut.im.Memory[4]  = 32'h0800_0001;  // j    1
        dut.im.Memory[6]  = 32'h0800_0003;  // j    3
        dut.im.Memory[7]  = 32'h0021_0020;  // add  $0,$1,$1
        dut.im.Memory[8]  = 32'h2004_FFFF;  // addi $4,$0,-1
        dut.im.Memory[9]  = 32'h0080_2820;  // add  $5,$4,$0
        dut.im.Memory[10] = 32'h0081_302A;  // slt  $6,$4,$1
        dut.im.Memory[11] = 32'h0024_3824;  // and  $7,$1,$4
        dut.im.Memory[12] = 32'h0024_4025;  // or   $8,$1,$4
        dut.im.Memory[13] = 32'h0024_4822;  // sub  $9,$1,$4
        for (int i = 0; i < 32; i++) dut.rf.RegFile[i] = 32'h0;
        dut.rf.RegFile[1] = 32'h1;
        dut.rf.RegFile[3] = 32'h55;
        dut.rf.RegFile[4] = 32'h1234;
        step();
        step();
        reset = 1'b0;

        // PC=0: add $2,$1,$1
        want(S_PC, 32'h0); want(S_INSTR, 32'h0021_1020); want(S_RD1, 32'h1);
        want(S_ALU, 32'h2); want(S_REGWRITE, 1); want(S_REGDST, 1); want(S_WREG, 2);
        want(S_ALUCTL, 3'b010); want(S_PCNEXT, 32'h4); want(S_DMEM0, 32'h0);
        step();
        // PC=4: lw $3,0($0)
        want(S_PC, 32'h4); want(S_REG2, 32'h2); want(S_ALUSRC, 1); want(S_MEMTOREG, 1);
        want(S_ALU, 32'h0); want(S_RDATA, 32'h0); want(S_RESULT, 32'h0); want(S_WREG, 3);
        want(S_REGDST, 0); want(S_PCNEXT, 32'h8);
        step();
        // PC=8: sw $2,0($0)
        want(S_RD2, 32'h2); want(S_MEMWRITE, 1); want(S_REGWRITE, 0); want(S_ALU, 32'h0);
        want(S_SRCB, 32'h0); want(S_PCNEXT, 32'hC);
        step();
        // PC=C: beq $2,$3,2 taken
        dut.rf.RegFile[3] = 32'h2;
        want(S_DMEM0, 32'h2); want(S_RDATA, 32'h2); want(S_RD1, 32'h2); want(S_RD2, 32'h2);
        want(S_BRANCH, 1); want(S_ALUCTL, 3'b110); want(S_ZERO, 1); want(S_PCSRC, 1);
        want(S_SIGNIMM, 32'h2); want(S_SHIFTED, 32'h8); want(S_PCPLUS4, 32'h10);
        want(S_PCBRANCH, 32'h18); want(S_PCNEXT, 32'h18); want(S_REGWRITE, 0);
        step();
        // PC=18: j 3
        want(S_PC, 32'h18); want(S_JUMP, 1); want(S_PCNEXT, 32'hC); want(S_REGWRITE, 0);
        want(S_MEMWRITE, 0);
        step();
        // PC=C: beq not taken with $3=1
        dut.rf.RegFile[3] = 32'h1;
        want(S_ZERO, 0); want(S_PCSRC, 0); want(S_ALU, 32'h1); want(S_PCNEXT, 32'h10);
        step();
        // PC=10: j 1
        want(S_PC, 32'h10); want(S_JUMP, 1); want(S_PCNEXT, 32'h4); want(S_REGWRITE, 0);
        want(S_MEMWRITE, 0); want(S_BRANCH, 0);
        step();
        // PC=4: lw now sees stored word
        want(S_PC, 32'h4); want(S_RDATA, 32'h2); want(S_RESULT, 32'h2); want(S_WREG, 3);
        step();
        // PC=8: sw, reset asserted for the coming edge
        want(S_PC, 32'h8); want(S_RD2, 32'h2); want(S_MEMWRITE, 1);
        reset = 1'b1;
        step();
        // reset held: PC=0, add would write $2=10 but must be suppressed
        dut.rf.RegFile[1] = 32'h5;
        want(S_PC, 32'h0); want(S_DMEM0, 32'h0); want(S_ALU, 32'hA); want(S_REG2, 32'h2);
        step();
        reset = 1'b0;
        // restart at 0
        dut.im.Memory[1] = 32'h0800_0007;  // j 7
        want(S_PC, 32'h0); want(S_REG2, 32'h2); want(S_ALU, 32'hA); want(S_RDATA, 32'h0);
        want(S_PCNEXT, 32'h4);
        step();
        // PC=4: j 7
        want(S_PC, 32'h4); want(S_REG2, 32'hA); want(S_JUMP, 1); want(S_PCNEXT, 32'h1C);
        step();
        // PC=1C: add $0,$1,$1
        want(S_PC, 32'h1C); want(S_ALU, 32'hA); want(S_WREG, 0); want(S_REGWRITE, 1);
        want(S_PCNEXT, 32'h20);
        step();
        // PC=20: addi $4,$0,-1
        want(S_PC, 32'h20); want(S_RD1, 32'h0); want(S_SIGNIMM, 32'hFFFF_FFFF);
        want(S_REGWRITE, 32'(ADDI)); want(S_ALUSRC, 32'(ADDI)); want(S_ALUCTL, 3'b010);
        want(S_ALU, ADDI ? 32'hFFFF_FFFF : 32'h1234); want(S_PCNEXT, 32'h24);
        step();
        // PC=24: add $5,$4,$0
        want(S_RD1, ADDI ? 32'hFFFF_FFFF : 32'h1234); want(S_ALU, ADDI ? 32'hFFFF_FFFF : 32'h1234);
        step();
        // PC=28: slt $6,$4,$1
        want(S_ALUCTL, 3'b111); want(S_ALU, ADDI ? 32'h1 : 32'h0);
        step();
        // PC=2C: and $7,$1,$4
        want(S_ALUCTL, 3'b000); want(S_ALU, ADDI ? 32'h5 : 32'h4);
        step();
        // PC=30: or $8,$1,$4
        want(S_ALUCTL, 3'b001); want(S_ALU, ADDI ? 32'hFFFF_FFFF : 32'h1235);
        step();
        // PC=34: sub $9,$1,$4
        want(S_ALUCTL, 3'b110); want(S_ALU, ADDI ? 32'h6 : 32'hFFFF_EDD1);
        step();
        // PC=38: undefined funct acts as nop
        want(S_PC, 32'h38); want(S_REGWRITE, 0); want(S_REGDST, 0); want(S_ALUCTL, 3'b010);
        want(S_MEMWRITE, 0); want(S_PCNEXT, 32'h3C);
        step();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_complete.md
# mips_complete

Single-cycle 32-bit MIPS subset processor with instruction memory, register file, data memory, ALU and main/ALU decoders in one top level. Every internal datapath and control signal is exported as an output port so a bench can trace execution cycle by cycle. It is the top of the processor design and has no external memory or bus interface.

## Interface
- Parameters: none. Memories are fixed at 64 words each.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- PC  out  32  current program counter
- PCNext  out  32  value PC loads at the next edge
- PCplus4  out  32  PC + 4
- Instr  out  32  instruction at PC
- Signlmm  out  32  sign-extended Instr[15:0]
- shifted  out  32  Signlmm << 2
- PCBranch  out  32  PCplus4 + shifted
- ReadData1 / ReadData2  out  32  register reads of rs / rt
- SrcB  out  32  ALU operand B: Signlmm if ALUSrc, else ReadData2
- ALUResult  out  32  ALU output
- Zero  out  1  ALUResult == 0
- ReadData  out  32  data-memory read at ALUResult
- Result  out  32  write-back value: ReadData if MemtoReg, else ALUResult
- WriteReg  out  5  destination: Instr[15:11] if RegDst, else Instr[20:16]
- RegWrite, RegDst, MemtoReg, MemWrite, Branch, ALUSrc, Jump  out  1 each  main-decoder controls
- ALUControl  out  3  ALU operation
- PCSrc  out  1  Branch & Zero

## Operation
- Supported instructions:
  - R-type (op 000000): add (funct 100000), sub (100010), and (100100), or (100101), slt (101010).
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (only when the macro below is defined).
- ALUControl encodings: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed; result 1 or 0).
- Control values per instruction:
  - R-type: RegWrite=1, RegDst=1; ALUControl from funct.
  - lw: RegWrite=1, ALUSrc=1, MemtoReg=1, add.
  - sw: MemWrite=1, ALUSrc=1, add.
  - beq: Branch=1, sub.
  - j: Jump=1.
  - addi: RegWrite=1, ALUSrc=1, add.
- Undefined opcode or funct: every control is 0 and ALUControl=010. The instruction acts as a nop.
- PCNext = Jump ? {PCplus4[31:28], Instr[25:0], 2'b00} : (PCSrc ? PCBranch : PCplus4).
- Memories are word-addressed.
  - Instruction memory index is PC[7:2]; data memory index is ALUResult[7:2].
  - Higher address bits are ignored, so addresses wrap modulo 256 bytes.
- Register $0 always reads 0. Writes to $0 are discarded.
- All additions wrap modulo 2^32. There is no overflow trap.

## Timing
- Single-cycle. All outputs are combinational from PC and stored state within the same cycle.
- On the rising edge, PC <= PCNext. The register file writes Result to WriteReg if RegWrite. The data memory writes ReadData2 if MemWrite.
- A read of a register being written in the same cycle returns the old value. The new value is visible from the next cycle.
- Reset:
  - At an edge with reset=1, PC <= 0 and every data-memory word <= 0.
  - Register and memory writes are suppressed in that cycle.
  - The register file and instruction memory are not reset, so benches can preload them.
- Reset can be asserted at any cycle. Execution restarts from address 0 on the first edge after reset deasserts.

## Configuration
- MIPS_COMPLETE_ADDI_EN defined: opcode 001000 decodes as addi.
- Not defined: opcode 001000 is undefined and acts as a nop.

## Structure
- Package mips_pkg holds:
  - opcode and funct localparams;
  - ALUControl encodings;
  - memory depth (64).
- Required sub-module instances, so benches can preload storage hierarchically:
  - mips_imem, instance name im, storage array Memory[0:63] of 32 bits, combinational read.
  - mips_regfile, instance name rf, storage array RegFile[0:31] of 32 bits, two combinational read ports, one synchronous write port.
- Decoders, ALU and data memory are inline in the top level.

## Test plan
- Preload $1=1; Memory[0]=add $2,$1,$1 -> ALUResult=2, RegWrite=1, WriteReg=2; $2=2 after the edge; PCNext=4.
- After reset, Memory[1]=lw $3,0($0) -> ALUSrc=1, MemtoReg=1, ReadData=0, $3=0 after the edge.
- Memory[2]=sw $2,0($0) with $2=2 -> MemWrite=1, RegWrite=0, ALUResult=0; data word 0 reads 2 afterwards.
- $2=$3=2; Memory[3]=beq $2,$3,2 at PC=0xC -> Zero=1, PCSrc=1, PCBranch=0x18, PCNext=0x18. With $3=1 instead -> PCNext=0x10.
- Memory[4]=j 1 at PC=0x10 -> Jump=1, PCNext=0x4, no register or memory write.
- Assert reset mid-program -> PC=0 next edge, no write that cycle; add $0,$1,$1 leaves $0 reading 0. addi $4,$0,-1 gives 0xFFFFFFFF with the macro defined, and no write without it.
